// File: rtl/gemm_seq_if.sv
// Memory request/response bus and NICE multicycle response channel of the GEMM sequencer.
// master: the sequencer (drives requests and the job response). slave: memory plus core side.
// No storage or flow control lives here; it only bundles the wires.
interface gemm_seq_if #(
  parameter int AW = 32
);
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_wr;
  logic [AW-1:0] mem_req_addr;
  logic [31:0]   mem_req_wdata;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_rdata;
  logic          mem_rsp_err;
  logic          nice_rsp_multicyc_valid;
  logic          nice_rsp_multicyc_ready;
  logic [31:0]   nice_rsp_multicyc_dat;
  logic          nice_rsp_multicyc_err;

  modport master (
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output nice_rsp_multicyc_valid, nice_rsp_multicyc_dat, nice_rsp_multicyc_err,
    input  nice_rsp_multicyc_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  nice_rsp_multicyc_valid, nice_rsp_multicyc_dat, nice_rsp_multicyc_err,
    output nice_rsp_multicyc_ready
  );
endinterface

// File: rtl/gemm_seq.sv
// GEMM sequencer + int8 MAC: walks r/c/k loops, reads lhs/rhs bytes, writes int32 dst words.
// Latency: 5 cycles per MAC step with zero-wait memory, plus >=1 writeback cycle per element.
// Backpressure: one memory request outstanding, held stable until mem_req_ready; response held until accepted.
// Optional GEMM_SEQ_RELU_EN: clamp negative results to 0 on writeback.
module gemm_seq #(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic        nice_clk,
  input  logic        nice_rst_n,
  input  logic        start,
  input  logic [31:0] lhs_cols,
  input  logic [31:0] lhs_rows,
  input  logic [31:0] rhs_cols,
  input  logic [31:0] lhs_addr,
  input  logic [31:0] rhs_addr,
  input  logic [31:0] dst_addr,
  output logic [1:0]  state,
  gemm_seq_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LHS, S_RD_RHS, S_MAC, S_WR_DST, S_RSP
  } fsm_t;

  fsm_t               fsm;
  logic [CW-1:0]      k_dim, m_dim, n_dim;
  logic [CW-1:0]      r, c, k;
  logic [AW-1:0]      lhs_base, rhs_base, dst_base;
  logic               wait_rsp;
  logic [1:0]         lane;
  logic signed [7:0]  lhs8, rhs8;
  logic [31:0]        acc, count;
  logic               err;
  logic               rsp_valid;
  logic [31:0]        rsp_dat;
  logic               rsp_err;

  logic [AW-1:0]      lhs_rd_addr, rhs_rd_addr, dst_wr_addr, req_addr;
  logic [31:0]        wr_val;
  logic [7:0]         rsp_byte;
  logic signed [15:0] prod;
  logic [CW-1:0]      k_last, c_last, r_last;
  logic               zero_dim;
  logic               unused_hi;

  // Only the low CW bits of each dimension are meaningful.
  assign unused_hi = ^{lhs_cols[31:CW], lhs_rows[31:CW], rhs_cols[31:CW]};

  assign prod     = lhs8 * rhs8;
  assign k_last   = k_dim - CW'(1);
  assign c_last   = n_dim - CW'(1);
  assign r_last   = m_dim - CW'(1);
  assign zero_dim = (lhs_cols[CW-1:0] == '0) || (lhs_rows[CW-1:0] == '0) ||
                    (rhs_cols[CW-1:0] == '0);

  // Operand/result addresses from the loop counters; arithmetic wraps in AW bits.
  always_comb begin
    lhs_rd_addr = lhs_base + AW'(r) * AW'(k_dim) + AW'(k);
    rhs_rd_addr = rhs_base + AW'(c) * AW'(k_dim) + AW'(k);
    dst_wr_addr = dst_base + ((AW'(r) * AW'(n_dim) + AW'(c)) << 2);
    case (fsm)
      S_RD_LHS: req_addr = lhs_rd_addr;
      S_RD_RHS: req_addr = rhs_rd_addr;
      S_WR_DST: req_addr = dst_wr_addr;
      default:  req_addr = '0;
    endcase
  end

  // Writeback value, optionally clamped at zero.
  always_comb begin
`ifdef GEMM_SEQ_RELU_EN
    wr_val = acc[31] ? 32'd0 : acc;
`else
    wr_val = acc;
`endif
  end

  // Little-endian byte lane picked by the low address bits of the request.
  always_comb begin
    case (lane)
      2'd0:    rsp_byte = bus.mem_rsp_rdata[7:0];
      2'd1:    rsp_byte = bus.mem_rsp_rdata[15:8];
      2'd2:    rsp_byte = bus.mem_rsp_rdata[23:16];
      default: rsp_byte = bus.mem_rsp_rdata[31:24];
    endcase
  end

  // Bus and state outputs are pure decodes of registered state, so they hold while stalled.
  always_comb begin
    bus.mem_req_valid = ((fsm == S_RD_LHS || fsm == S_RD_RHS) && !wait_rsp) || (fsm == S_WR_DST);
    bus.mem_req_wr    = (fsm == S_WR_DST);
    bus.mem_req_addr  = req_addr;
    bus.mem_req_wdata = (fsm == S_WR_DST) ? wr_val : 32'd0;
    bus.nice_rsp_multicyc_valid = rsp_valid;
    bus.nice_rsp_multicyc_dat   = rsp_dat;
    bus.nice_rsp_multicyc_err   = rsp_err;
    case (fsm)
      S_IDLE:   state = 2'b00;
      S_WR_DST: state = 2'b10;
      S_RSP:    state = 2'b11;
      default:  state = 2'b01;
    endcase
  end

  // Job sequencer: loop counters, operand fetch, MAC, writeback and response.
  always_ff @(posedge nice_clk or negedge nice_rst_n) begin
    if (!nice_rst_n) begin
      fsm       <= S_IDLE;
      k_dim     <= '0;
      m_dim     <= '0;
      n_dim     <= '0;
      r         <= '0;
      c         <= '0;
      k         <= '0;
      lhs_base  <= '0;
      rhs_base  <= '0;
      dst_base  <= '0;
      wait_rsp  <= 1'b0;
      lane      <= 2'd0;
      lhs8      <= '0;
      rhs8      <= '0;
      acc       <= '0;
      count     <= '0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start) begin
            k_dim    <= lhs_cols[CW-1:0];
            m_dim    <= lhs_rows[CW-1:0];
            n_dim    <= rhs_cols[CW-1:0];
            lhs_base <= AW'(lhs_addr);
            rhs_base <= AW'(rhs_addr);
            dst_base <= AW'(dst_addr);
            r        <= '0;
            c        <= '0;
            k        <= '0;
            acc      <= '0;
            count    <= '0;
            err      <= 1'b0;
            wait_rsp <= 1'b0;
            if (zero_dim) begin
              fsm       <= S_RSP;
              rsp_valid <= 1'b1;
              rsp_dat   <= 32'd0;
              rsp_err   <= 1'b0;
            end else begin
              fsm <= S_RD_LHS;
            end
          end
        end
        S_RD_LHS, S_RD_RHS: begin
          if (!wait_rsp) begin
            if (bus.mem_req_ready) begin
              wait_rsp <= 1'b1;
              lane     <= req_addr[1:0];
            end
          end else if (bus.mem_rsp_valid) begin
            wait_rsp <= 1'b0;
            err      <= err | bus.mem_rsp_err;
            if (fsm == S_RD_LHS) begin
              lhs8 <= signed'(rsp_byte);
              fsm  <= S_RD_RHS;
            end else begin
              rhs8 <= signed'(rsp_byte);
              fsm  <= S_MAC;
            end
          end
        end
        S_MAC: begin
          acc <= acc + {{16{prod[15]}}, prod};
          if (k == k_last) begin
            fsm <= S_WR_DST;
          end else begin
            k   <= k + CW'(1);
            fsm <= S_RD_LHS;
          end
        end
        S_WR_DST: begin
          if (bus.mem_req_ready) begin
            count <= count + 32'd1;
            k     <= '0;
            acc   <= '0;
            fsm   <= S_RD_LHS;
            if (c == c_last) begin
              c <= '0;
              if (r == r_last) begin
                fsm       <= S_RSP;
                rsp_valid <= 1'b1;
                rsp_dat   <= count + 32'd1;
                rsp_err   <= err;
              end else begin
                r <= r + CW'(1);
              end
            end else begin
              c <= c + CW'(1);
            end
          end
        end
        S_RSP: begin
          if (bus.nice_rsp_multicyc_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            fsm       <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
